// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read splitter: response codes,
// controller state encoding and a constant-width helper.
package ddr_rd_pkg;

    localparam logic [1:0] RESP_OKAY = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2, usable in localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_read_splitter_if.sv
// Bundles the job request, datamover command/data/response and consumer
// data signals of the DDR read splitter into one interface.
interface ddr_read_splitter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int SIZE_WIDTH = 16,
    parameter int LEN_WIDTH  = 32
);

    logic                  req_ready;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  ddr_rreq_ready;
    logic                  ddr_rreq_valid;
    logic [ADDR_WIDTH-1:0] ddr_rreq_addr;
    logic [SIZE_WIDTH-1:0] ddr_rreq_size;

    logic                  ddr_rdata_ready;
    logic                  ddr_rdata_valid;
    logic                  ddr_rdata_last;
    logic [DATA_WIDTH-1:0] ddr_rdata;

    logic                  ddr_rresp_valid;
    logic [1:0]            ddr_rresp;

    logic                  m_rdata_ready;
    logic                  m_rdata_valid;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_rdata_last;

    logic                  done_valid;
    logic [1:0]            done_resp;
    logic                  busy;

    // The splitter itself.
    modport slave (
        output req_ready,
        input  req_valid, req_addr, req_len,
        input  ddr_rreq_ready,
        output ddr_rreq_valid, ddr_rreq_addr, ddr_rreq_size,
        output ddr_rdata_ready,
        input  ddr_rdata_valid, ddr_rdata_last, ddr_rdata,
        input  ddr_rresp_valid, ddr_rresp,
        input  m_rdata_ready,
        output m_rdata_valid, m_rdata, m_rdata_last,
        output done_valid, done_resp, busy
    );

    // The surrounding system: job source, datamover and data consumer.
    modport master (
        input  req_ready,
        output req_valid, req_addr, req_len,
        output ddr_rreq_ready,
        input  ddr_rreq_valid, ddr_rreq_addr, ddr_rreq_size,
        input  ddr_rdata_ready,
        output ddr_rdata_valid, ddr_rdata_last, ddr_rdata,
        output ddr_rresp_valid, ddr_rresp,
        output m_rdata_ready,
        input  m_rdata_valid, m_rdata, m_rdata_last,
        input  done_valid, done_resp, busy
    );

endinterface

// File: rtl/ddr_rd_chunk_calc.sv
// Size of the next command: the remaining job length clipped to the distance
// from addr to the next CHUNK_BYTES boundary.
module ddr_rd_chunk_calc #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 32,
    parameter int SIZE_WIDTH  = 16,
    parameter int CHUNK_BYTES = 4096
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [SIZE_WIDTH-1:0] size
);

    logic [ADDR_WIDTH-1:0] offset;
    logic [LEN_WIDTH-1:0]  room;

    always_comb begin
        offset = addr & ADDR_WIDTH'(CHUNK_BYTES - 1);
        room   = LEN_WIDTH'(CHUNK_BYTES) - LEN_WIDTH'(offset);
        // room never exceeds CHUNK_BYTES, which fits in SIZE_WIDTH
        if (remaining < room) begin
            size = SIZE_WIDTH'(remaining);
        end else begin
            size = SIZE_WIDTH'(room);
        end
    end

endmodule

// File: rtl/ddr_read_splitter.sv
// Splits one byte-addressed read job into chunk-aligned datamover commands,
// limits commands in flight, and folds per-chunk results into one completion.
module ddr_read_splitter
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int SIZE_WIDTH      = 16,
    parameter int LEN_WIDTH       = 32,
    parameter int CHUNK_BYTES     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    ddr_read_splitter_if.slave bus
);

    localparam int CNT_W = LEN_WIDTH - clog2(CHUNK_BYTES) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]      cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]      resp_cnt_q, resp_cnt_d;
    logic [CNT_W-1:0]      last_cnt_q, last_cnt_d;
    logic [1:0]            status_q, status_d;
    logic                  issue_done_q, issue_done_d;
    logic                  req_ready_q, req_ready_d;

    logic [SIZE_WIDTH-1:0] chunk_size;
    logic [CNT_W-1:0]      outstanding;
    logic                  job_active;
    logic                  cmd_valid;
    logic                  cmd_fire;
    logic                  resp_fire;
    logic                  last_fire;
    logic                  req_fire;

    ddr_rd_chunk_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .SIZE_WIDTH (SIZE_WIDTH),
        .CHUNK_BYTES(CHUNK_BYTES)
    ) u_chunk_calc (
        .addr     (addr_q),
        .remaining(remaining_q),
        .size     (chunk_size)
    );

    // Responses and last beats seen in IDLE belong to an abandoned job.
    always_comb begin
        job_active  = (state_q != IDLE);
        outstanding = cmd_cnt_q - resp_cnt_q;
        cmd_valid   = (state_q == ISSUE) && (outstanding < CNT_W'(MAX_OUTSTANDING));
        cmd_fire    = cmd_valid && bus.ddr_rreq_ready;
        resp_fire   = job_active && bus.ddr_rresp_valid;
        last_fire   = job_active && bus.ddr_rdata_valid && bus.m_rdata_ready
                      && bus.ddr_rdata_last;
        req_fire    = (state_q == IDLE) && req_ready_q && bus.req_valid;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        cmd_cnt_d    = cmd_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        last_cnt_d   = last_cnt_q;
        status_d     = status_q;
        issue_done_d = issue_done_q;

        if (resp_fire) begin
            resp_cnt_d = resp_cnt_q + CNT_W'(1);
            status_d   = status_q | bus.ddr_rresp;
        end
        if (last_fire) begin
            last_cnt_d = last_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    addr_d       = bus.req_addr;
                    remaining_d  = bus.req_len;
                    cmd_cnt_d    = '0;
                    resp_cnt_d   = '0;
                    last_cnt_d   = '0;
                    status_d     = RESP_OKAY;
                    issue_done_d = 1'b0;
                    state_d      = (bus.req_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_fire) begin
                    addr_d      = addr_q + ADDR_WIDTH'(chunk_size);
                    remaining_d = remaining_q - LEN_WIDTH'(chunk_size);
                    cmd_cnt_d   = cmd_cnt_q + CNT_W'(1);
                    if (remaining_d == '0) begin
                        issue_done_d = 1'b1;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((resp_cnt_q == cmd_cnt_q) && (last_cnt_q == cmd_cnt_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            cmd_cnt_q    <= '0;
            resp_cnt_q   <= '0;
            last_cnt_q   <= '0;
            status_q     <= RESP_OKAY;
            issue_done_q <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            cmd_cnt_q    <= cmd_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            last_cnt_q   <= last_cnt_d;
            status_q     <= status_d;
            issue_done_q <= issue_done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Address and size come straight from state, so they hold while stalled.
    assign bus.req_ready      = req_ready_q;
    assign bus.ddr_rreq_valid = cmd_valid;
    assign bus.ddr_rreq_addr  = addr_q;
    assign bus.ddr_rreq_size  = chunk_size;

    assign bus.ddr_rdata_ready = bus.m_rdata_ready;
    assign bus.m_rdata_valid   = bus.ddr_rdata_valid;
    assign bus.m_rdata         = bus.ddr_rdata;
    assign bus.m_rdata_last    = bus.ddr_rdata_last && issue_done_q
                                 && ((last_cnt_q + CNT_W'(1)) == cmd_cnt_q);

    assign bus.done_valid = (state_q == DONE);
    assign bus.done_resp  = (state_q == DONE) ? status_q : RESP_OKAY;
    assign bus.busy       = job_active;

endmodule

// File: tb/tb_ddr_read_splitter.sv
// Randomized bench for ddr_read_splitter: a behavioural model of the job
// split, flow control and status folding checks every cycle.
module tb_ddr_read_splitter;
    import ddr_rd_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int SW    = 16;
    localparam int LW    = 32;
    localparam int CHUNK = 4096;
    localparam int MAXO  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr_read_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

    ddr_read_splitter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .LEN_WIDTH(LW),
        .CHUNK_BYTES(CHUNK), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid       = 1'b0;
        bus.req_addr        = '0;
        bus.req_len         = '0;
        bus.ddr_rreq_ready  = 1'b0;
        bus.ddr_rdata_valid = 1'b0;
        bus.ddr_rdata_last  = 1'b0;
        bus.ddr_rdata       = '0;
        bus.ddr_rresp_valid = 1'b0;
        bus.ddr_rresp       = '0;
        bus.m_rdata_ready   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_rreq_valid"}, bus.ddr_rreq_valid, 0);
        check_eq({tag, "_rreq_addr"}, bus.ddr_rreq_addr, 0);
        check_eq({tag, "_rreq_size"}, bus.ddr_rreq_size, 0);
        check_eq({tag, "_done_valid"}, bus.done_valid, 0);
        check_eq({tag, "_done_resp"}, bus.done_resp, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic wait_req_ready();
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("req_ready_wait", bus.req_ready, 1);
    endtask

    // hold: cycles with ddr_rreq_ready low; withhold: cycles with no responses
    // (ready forced high meanwhile); err_idx: chunk answering RESP_ERR.
    task automatic run_job(input logic [31:0] addr, input logic [31:0] len, input int err_idx,
                           input int withhold, input int hold, input bit rnd_err);
        logic [31:0] exp_addr[$];
        int          exp_size[$];
        int          beats_q[$];
        int          owner_q[$];
        logic [1:0]  resp_q[$];
        logic [31:0] a;
        logic [31:0] prev_a;
        logic [63:0] word;
        logic [1:0]  status;
        logic [1:0]  rv_val;
        longint      rem;
        int          sz, total, issued, responded, lasts, cyc, after, prev_s;
        bit          done_seen, prev_stall, dv, rv, mrdy, all_done, exp_v, exp_last;

        a = addr;
        rem = longint'(len);
        while (rem > 0) begin
            sz = CHUNK - int'(a % CHUNK);
            if (rem < longint'(sz)) sz = int'(rem);
            exp_addr.push_back(a);
            exp_size.push_back(sz);
            a = a + sz;
            rem = rem - sz;
        end
        total = exp_addr.size();

        wait_req_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        status = RESP_OKAY;
        if (total == 0) begin
            check_eq("zero_done_valid", bus.done_valid, 1);
            check_eq("zero_done_resp", bus.done_resp, 0);
            check_eq("zero_rreq_valid", bus.ddr_rreq_valid, 0);
            @(posedge clk);
            #1;
            check_eq("zero_done_low", bus.done_valid, 0);
            check_eq("zero_req_ready", bus.req_ready, 1);
            check_eq("zero_rreq_valid2", bus.ddr_rreq_valid, 0);
            $display("job addr=0x%08h len=0x%0h cmds=0 resp=%0d", addr, len, bus.done_resp);
            return;
        end

        issued = 0; responded = 0; lasts = 0; cyc = 0; after = 0;
        done_seen = 0; prev_stall = 0; prev_a = '0; prev_s = 0;
        while (!done_seen && cyc < 5000) begin
            // drive this cycle's inputs
            if (cyc < hold) bus.ddr_rreq_ready = 1'b0;
            else if (cyc < withhold) bus.ddr_rreq_ready = 1'b1;
            else bus.ddr_rreq_ready = ($urandom_range(0, 3) != 0);
            mrdy = ($urandom_range(0, 3) != 0);
            bus.m_rdata_ready = mrdy;
            dv = (beats_q.size() > 0) && ($urandom_range(0, 3) != 0);
            word = {$urandom, $urandom};
            bus.ddr_rdata_valid = dv;
            bus.ddr_rdata       = dv ? word : '0;
            exp_last = 0;
            bus.ddr_rdata_last = 1'b0;
            if (dv) begin
                bus.ddr_rdata_last = (beats_q[0] == 1);
                exp_last = (beats_q[0] == 1) && (owner_q[0] == total - 1);
            end
            rv = (resp_q.size() > 0) &&
                 ((withhold > 0 && cyc == withhold) || (cyc > withhold && $urandom_range(0, 2) == 0));
            rv_val = rv ? resp_q[0] : 2'd0;
            bus.ddr_rresp_valid = rv;
            bus.ddr_rresp       = rv_val;
            #1;

            // compare against the model state before this cycle's handshakes
            exp_v = (issued < total) && ((issued - responded) < MAXO);
            check_eq("rreq_valid", bus.ddr_rreq_valid, exp_v);
            if (prev_stall) begin
                check_eq("stall_addr", bus.ddr_rreq_addr, prev_a);
                check_eq("stall_size", bus.ddr_rreq_size, prev_s);
            end
            if (bus.ddr_rreq_valid && issued < total) begin
                check_eq("cmd_addr", bus.ddr_rreq_addr, exp_addr[issued]);
                check_eq("cmd_size", bus.ddr_rreq_size, exp_size[issued]);
            end
            if (withhold > 0 && cyc == withhold)
                check_eq("withheld_cmds", issued, (total < MAXO) ? total : MAXO);
            if (withhold > 0 && cyc == withhold + 1 && issued < total)
                check_eq("fifth_cmd_valid", bus.ddr_rreq_valid, 1);
            check_eq("m_valid", bus.m_rdata_valid, dv);
            if (dv) check_eq("m_rdata", bus.m_rdata, word);
            check_eq("rdata_ready", bus.ddr_rdata_ready, mrdy);
            check_eq("m_last", bus.m_rdata_last, exp_last);
            check_eq("busy", bus.busy, 1);
            all_done = (issued == total) && (responded == total) && (lasts == total);
            if (!all_done) begin
                check_eq("early_done", bus.done_valid, 0);
            end else if (bus.done_valid === 1'b1) begin
                check_eq("done_resp", bus.done_resp, status);
                done_seen = 1;
            end else begin
                after++;
                if (after > 3) begin
                    check_eq("done_timeout", 0, 1);
                    break;
                end
            end

            // apply handshakes occurring at the coming edge
            prev_stall = bus.ddr_rreq_valid && !bus.ddr_rreq_ready;
            prev_a = bus.ddr_rreq_addr;
            prev_s = int'(bus.ddr_rreq_size);
            if (bus.ddr_rreq_valid && bus.ddr_rreq_ready && issued < total) begin
                if (issued == err_idx || (rnd_err && $urandom_range(0, 7) == 0))
                    resp_q.push_back(RESP_ERR);
                else
                    resp_q.push_back(RESP_OKAY);
                beats_q.push_back($urandom_range(1, 3));
                owner_q.push_back(issued);
                issued++;
            end
            if (dv && mrdy) begin
                beats_q[0] = beats_q[0] - 1;
                if (beats_q[0] == 0) begin
                    void'(beats_q.pop_front());
                    void'(owner_q.pop_front());
                    lasts++;
                end
            end
            if (rv) begin
                status = status | resp_q.pop_front();
                responded++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done_seen) check_eq("job_complete", 0, 1);
        clear_inputs();
        check_eq("post_done_low", bus.done_valid, 0);
        check_eq("post_req_ready", bus.req_ready, 1);
        check_eq("post_busy", bus.busy, 0);
        $display("job addr=0x%08h len=0x%0h cmds=%0d resp=%0d cycles=%0d", addr, len, total, status, cyc);
    endtask

    task automatic reset_mid_job();
        wait_req_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_len   = 32'h8000;
        @(posedge clk);
        #1;
        bus.req_valid      = 1'b0;
        bus.ddr_rreq_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ddr_rreq_ready  = 1'b0;
        bus.ddr_rresp_valid = 1'b1;
        bus.ddr_rresp       = RESP_ERR;
        #1;
        check_eq("mid_rst_req_ready0", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.ddr_rresp_valid = 1'b0;
        bus.ddr_rresp       = '0;
        check_eq("mid_rst_req_ready1", bus.req_ready, 1);
        check_eq("mid_rst_idle_done", bus.done_valid, 0);
        $display("job reset mid-flight");
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", bus.req_ready, 0);
        @(posedge clk);
        #1;
        check_eq("ready_first_clk", bus.req_ready, 1);

        run_job(32'h1000, 32'h3000, -1, 0, 0, 0);
        run_job(32'h0F00, 32'h300, -1, 0, 0, 0);
        run_job(32'h0, 32'h8000, -1, 30, 0, 0);
        run_job(32'h2345, 32'h4000, 1, 0, 0, 0);
        run_job(32'h40, 32'h0, -1, 0, 0, 0);
        run_job(32'h1800, 32'h2000, -1, 0, 10, 0);
        reset_mid_job();
        run_job(32'h3000, 32'h2800, -1, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            run_job(32'($urandom_range(0, 32'hFFFF)), 32'($urandom_range(0, 5 * CHUNK)), -1, 0,
                    $urandom_range(0, 4), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule
